// File: rtl/ascii_scancode_tx.sv
// ASCII -> PS/2 Set 2 make/break byte sequencer with Left-Shift wrapping.
// Optional Ctrl+letter mapping of 0x01-0x1A when ASCII_SCANTX_CTRL_EN is defined.
module ascii_scancode_tx #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ascii_valid,
    input  logic [6:0] ascii_data,
    output logic       ascii_ready,
    output logic       sc_valid,
    output logic [7:0] sc_data,
    input  logic       sc_ready,
    output logic       busy,
    output logic       unmapped
);

    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [7:0] BRK_CODE   = 8'hF0;
    localparam logic [7:0] LSHIFT_KEY = 8'h12;
    localparam logic [7:0] LCTRL_KEY  = 8'h14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOD_MK,
        S_KEY_MK,
        S_BRK1,
        S_KEY_BRK,
        S_BRK2,
        S_MOD_BRK,
        S_GAP
    } state_t;

    typedef struct packed {
        logic       hit;
        logic       has_mod;
        logic [7:0] mod;
        logic [7:0] key;
    } map_t;

    function automatic logic [7:0] letter_code(input logic [4:0] idx);
        logic [7:0] k;
        case (idx)
            5'd0:  k = 8'h1C;  5'd1:  k = 8'h32;  5'd2:  k = 8'h21;  5'd3:  k = 8'h23;
            5'd4:  k = 8'h24;  5'd5:  k = 8'h2B;  5'd6:  k = 8'h34;  5'd7:  k = 8'h33;
            5'd8:  k = 8'h43;  5'd9:  k = 8'h3B;  5'd10: k = 8'h42;  5'd11: k = 8'h4B;
            5'd12: k = 8'h3A;  5'd13: k = 8'h31;  5'd14: k = 8'h44;  5'd15: k = 8'h4D;
            5'd16: k = 8'h15;  5'd17: k = 8'h2D;  5'd18: k = 8'h1B;  5'd19: k = 8'h2C;
            5'd20: k = 8'h3C;  5'd21: k = 8'h2A;  5'd22: k = 8'h1D;  5'd23: k = 8'h22;
            5'd24: k = 8'h35;  5'd25: k = 8'h1A;
            default: k = 8'h00;
        endcase
        return k;
    endfunction

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        logic [7:0] k;
        case (d)
            4'd0: k = 8'h45;  4'd1: k = 8'h16;  4'd2: k = 8'h1E;  4'd3: k = 8'h26;
            4'd4: k = 8'h25;  4'd5: k = 8'h2E;  4'd6: k = 8'h36;  4'd7: k = 8'h3D;
            4'd8: k = 8'h3E;  4'd9: k = 8'h46;
            default: k = 8'h00;
        endcase
        return k;
    endfunction

    function automatic map_t plain(input logic [7:0] k);
        return {1'b1, 1'b0, LSHIFT_KEY, k};
    endfunction

    function automatic map_t shifted(input logic [7:0] k);
        return {1'b1, 1'b1, LSHIFT_KEY, k};
    endfunction

    function automatic map_t lookup(input logic [6:0] c);
        map_t m;
        m = '0;
        if (c >= 7'h61 && c <= 7'h7A) begin
            m = plain(letter_code(5'(c - 7'h61)));
        end else if (c >= 7'h41 && c <= 7'h5A) begin
            m = shifted(letter_code(5'(c - 7'h41)));
        end else if (c >= 7'h30 && c <= 7'h39) begin
            m = plain(digit_code(4'(c - 7'h30)));
        end else begin
            case (c)
                7'h20: m = plain(8'h29);   7'h08: m = plain(8'h66);
                7'h09: m = plain(8'h0D);   7'h0A: m = plain(8'h5A);
                7'h1B: m = plain(8'h76);
                7'h60: m = plain(8'h0E);   7'h2D: m = plain(8'h4E);
                7'h3D: m = plain(8'h55);   7'h5B: m = plain(8'h54);
                7'h5D: m = plain(8'h5B);   7'h5C: m = plain(8'h5D);
                7'h3B: m = plain(8'h4C);   7'h27: m = plain(8'h52);
                7'h2C: m = plain(8'h41);   7'h2E: m = plain(8'h49);
                7'h2F: m = plain(8'h4A);
                7'h7E: m = shifted(8'h0E); 7'h21: m = shifted(8'h16);
                7'h40: m = shifted(8'h1E); 7'h23: m = shifted(8'h26);
                7'h24: m = shifted(8'h25); 7'h25: m = shifted(8'h2E);
                7'h5E: m = shifted(8'h36); 7'h26: m = shifted(8'h3D);
                7'h2A: m = shifted(8'h3E); 7'h28: m = shifted(8'h46);
                7'h29: m = shifted(8'h45); 7'h5F: m = shifted(8'h4E);
                7'h2B: m = shifted(8'h55); 7'h7B: m = shifted(8'h54);
                7'h7D: m = shifted(8'h5B); 7'h7C: m = shifted(8'h5D);
                7'h3A: m = shifted(8'h4C); 7'h22: m = shifted(8'h52);
                7'h3C: m = shifted(8'h41); 7'h3E: m = shifted(8'h49);
                7'h3F: m = shifted(8'h4A);
                default: begin
`ifdef ASCII_SCANTX_CTRL_EN
                    // BS/HT/LF/ESC are decoded above, so the rest of 01-1A is Ctrl+letter
                    if (c >= 7'h01 && c <= 7'h1A) begin
                        m = {1'b1, 1'b1, LCTRL_KEY, letter_code(5'(c - 7'h01))};
                    end
`endif
                end
            endcase
        end
        return m;
    endfunction

    function automatic state_t next_emit(input state_t st, input logic has_mod);
        state_t n;
        case (st)
            S_MOD_MK:  n = S_KEY_MK;
            S_KEY_MK:  n = S_BRK1;
            S_BRK1:    n = S_KEY_BRK;
            S_KEY_BRK: n = has_mod ? S_BRK2 : S_IDLE;
            S_BRK2:    n = S_MOD_BRK;
            default:   n = S_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] state_byte(input state_t st, input logic [7:0] key,
                                              input logic [7:0] mod);
        logic [7:0] b;
        case (st)
            S_MOD_MK, S_MOD_BRK: b = mod;
            S_KEY_MK, S_KEY_BRK: b = key;
            default:             b = BRK_CODE;
        endcase
        return b;
    endfunction

    state_t           state_q;
    state_t           ret_q;
    logic [GCW-1:0]   gap_q;
    logic [7:0]       key_q;
    logic [7:0]       mod_q;
    logic             has_mod_q;
    logic             sc_valid_q;
    logic [7:0]       sc_data_q;
    logic             ascii_ready_q;
    logic             unmapped_q;

    map_t             acc_map;
    state_t           nxt_emit;
    logic             accept;

    assign acc_map  = lookup(ascii_data);
    assign nxt_emit = next_emit(state_q, has_mod_q);
    assign accept   = ascii_valid & ascii_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ret_q         <= S_IDLE;
            gap_q         <= '0;
            key_q         <= 8'h00;
            mod_q         <= 8'h00;
            has_mod_q     <= 1'b0;
            sc_valid_q    <= 1'b0;
            sc_data_q     <= 8'h00;
            ascii_ready_q <= 1'b1;
            unmapped_q    <= 1'b0;
        end else begin
            unmapped_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // ascii_ready low in IDLE only for the cycle after an unmapped char
                    if (!ascii_ready_q) begin
                        ascii_ready_q <= 1'b1;
                    end else if (ascii_valid) begin
                        ascii_ready_q <= 1'b0;
                        if (acc_map.hit) begin
                            key_q      <= acc_map.key;
                            mod_q      <= acc_map.mod;
                            has_mod_q  <= acc_map.has_mod;
                            state_q    <= acc_map.has_mod ? S_MOD_MK : S_KEY_MK;
                            sc_valid_q <= 1'b1;
                            sc_data_q  <= acc_map.has_mod ? acc_map.mod : acc_map.key;
                        end else begin
                            unmapped_q <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q    <= ret_q;
                        sc_valid_q <= 1'b1;
                        sc_data_q  <= state_byte(ret_q, key_q, mod_q);
                    end else begin
                        gap_q <= gap_q - GCW'(1);
                    end
                end
                default: begin
                    if (sc_ready) begin
                        if (nxt_emit == S_IDLE) begin
                            state_q       <= S_IDLE;
                            sc_valid_q    <= 1'b0;
                            ascii_ready_q <= 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state_q    <= S_GAP;
                            ret_q      <= nxt_emit;
                            gap_q      <= GCW'(GAP_CYCLES - 1);
                            sc_valid_q <= 1'b0;
                        end else begin
                            state_q   <= nxt_emit;
                            sc_data_q <= state_byte(nxt_emit, key_q, mod_q);
                        end
                    end
                end
            endcase
        end
    end

    assign ascii_ready = ascii_ready_q;
    assign sc_valid    = sc_valid_q;
    assign sc_data     = sc_data_q;
    assign unmapped    = unmapped_q;
    assign busy        = ~ascii_ready_q | accept;

endmodule

// File: tb/tb_ascii_scancode_tx.sv
// Directed bench for ascii_scancode_tx: vector table plus stall, gap and reset sequences.
module tb_ascii_scancode_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ascii_valid = 1'b0;
    logic [6:0] ascii_data = 7'h00;
    logic       ascii_ready;
    logic       sc_valid;
    logic [7:0] sc_data;
    logic       sc_ready = 1'b1;
    logic       busy;
    logic       unmapped;

    logic       g_ascii_valid = 1'b0;
    logic       g_ascii_ready;
    logic       g_sc_valid;
    logic [7:0] g_sc_data;
    logic       g_sc_ready = 1'b1;
    logic       g_busy;
    logic       g_unmapped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ascii_scancode_tx #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .ascii_valid(ascii_valid), .ascii_data(ascii_data),
        .ascii_ready(ascii_ready), .sc_valid(sc_valid), .sc_data(sc_data),
        .sc_ready(sc_ready), .busy(busy), .unmapped(unmapped)
    );

    ascii_scancode_tx #(.GAP_CYCLES(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .ascii_valid(g_ascii_valid), .ascii_data(ascii_data),
        .ascii_ready(g_ascii_ready), .sc_valid(g_sc_valid), .sc_data(g_sc_data),
        .sc_ready(g_sc_ready), .busy(g_busy), .unmapped(g_unmapped)
    );

    typedef struct {
        logic [6:0]  c;
        int          n;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_check(input logic [6:0] c, input int n, input logic [47:0] exp);
        int busy_cnt;
        @(posedge clk); #1;
        chk("idle_ready", 32'(ascii_ready), 1);
        ascii_data  = c;
        ascii_valid = 1'b1;
        sc_ready    = 1'b1;
        #1;
        busy_cnt = busy ? 1 : 0;
        @(posedge clk); #1;
        ascii_valid = 1'b0;
        if (n == 0) begin
            chk("unmapped_pulse", 32'(unmapped), 1);
            chk("unmapped_no_valid", 32'(sc_valid), 0);
            chk("unmapped_ready_low", 32'(ascii_ready), 0);
            @(posedge clk); #1;
            chk("unmapped_clear", 32'(unmapped), 0);
            chk("unmapped_ready_back", 32'(ascii_ready), 1);
            chk("unmapped_no_valid2", 32'(sc_valid), 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                chk("sc_valid", 32'(sc_valid), 1);
                chk("sc_data", 32'(sc_data), 32'(exp[47-8*i -: 8]));
                chk("no_unmapped", 32'(unmapped), 0);
                if (busy) busy_cnt++;
                @(posedge clk); #1;
            end
            chk("end_ready", 32'(ascii_ready), 1);
            chk("end_valid", 32'(sc_valid), 0);
            chk("end_busy", 32'(busy), 0);
            chk("sc_data_hold", 32'(sc_data), 32'(exp[47-8*(n-1) -: 8]));
            chk("busy_cycles", 32'(busy_cnt), 32'(n + 1));
        end
    endtask

    initial begin
        vecs[0]  = '{7'h61, 3, 48'h1CF01C000000};
        vecs[1]  = '{7'h41, 6, 48'h121CF01CF012};
        vecs[2]  = '{7'h3F, 6, 48'h124AF04AF012};
        vecs[3]  = '{7'h7F, 0, 48'h0};
        vecs[4]  = '{7'h00, 0, 48'h0};
        vecs[5]  = '{7'h20, 3, 48'h29F029000000};
        vecs[6]  = '{7'h30, 3, 48'h45F045000000};
        vecs[7]  = '{7'h29, 6, 48'h1245F045F012};
        vecs[8]  = '{7'h0A, 3, 48'h5AF05A000000};
        vecs[9]  = '{7'h1B, 3, 48'h76F076000000};
        vecs[10] = '{7'h7E, 6, 48'h120EF00EF012};
        vecs[11] = '{7'h2F, 3, 48'h4AF04A000000};
        vecs[12] = '{7'h22, 6, 48'h1252F052F012};
`ifdef ASCII_SCANTX_CTRL_EN
        vecs[13] = '{7'h03, 6, 48'h1421F021F014};
`else
        vecs[13] = '{7'h03, 0, 48'h0};
`endif

        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ascii_ready), 1);
        chk("rst_valid", 32'(sc_valid), 0);
        chk("rst_data", 32'(sc_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_unmapped", 32'(unmapped), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            send_check(vecs[v].c, vecs[v].n, vecs[v].bytes);
        end

        // 'z' with consumer stalled on the break byte; a char offered while busy is ignored
        @(posedge clk); #1;
        ascii_data = 7'h7A; ascii_valid = 1'b1; sc_ready = 1'b1;
        @(posedge clk); #1;
        ascii_valid = 1'b0;
        chk("stall_b0", 32'(sc_data), 32'h1A);
        @(posedge clk); #1;
        sc_ready = 1'b0;
        ascii_data = 7'h71; ascii_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(sc_valid), 1);
            chk("stall_data", 32'(sc_data), 32'hF0);
            chk("stall_ready_low", 32'(ascii_ready), 0);
            @(posedge clk); #1;
        end
        ascii_valid = 1'b0;
        chk("stall_hold_end", 32'(sc_data), 32'hF0);
        sc_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_b2_valid", 32'(sc_valid), 1);
        chk("stall_b2", 32'(sc_data), 32'h1A);
        @(posedge clk); #1;
        chk("stall_done_ready", 32'(ascii_ready), 1);
        chk("stall_done_valid", 32'(sc_valid), 0);

        // GAP_CYCLES=2 instance: '1' -> 16, gap, gap, F0, gap, gap, 16
        begin
            logic [6:0]  gv;
            logic [55:0] gd;
            gv = 7'b1001001;
            gd = 56'h161616F0F0F016;
            @(posedge clk); #1;
            ascii_data = 7'h31; g_ascii_valid = 1'b1;
            @(posedge clk); #1;
            g_ascii_valid = 1'b0;
            for (int i = 0; i < 7; i++) begin
                chk("gap_valid", 32'(g_sc_valid), 32'(gv[6-i]));
                chk("gap_data", 32'(g_sc_data), 32'(gd[55-8*i -: 8]));
                chk("gap_busy", 32'(g_busy), 1);
                @(posedge clk); #1;
            end
            chk("gap_done_ready", 32'(g_ascii_ready), 1);
            chk("gap_done_valid", 32'(g_sc_valid), 0);
            chk("gap_no_unmapped", 32'(g_unmapped), 0);
        end

        // reset in the middle of 'Q' (12,15,F0,...): abandon, then '\n' works normally
        @(posedge clk); #1;
        ascii_data = 7'h51; ascii_valid = 1'b1; sc_ready = 1'b1;
        @(posedge clk); #1;
        ascii_valid = 1'b0;
        chk("q_b0", 32'(sc_data), 32'h12);
        @(posedge clk); #1;
        chk("q_b1", 32'(sc_data), 32'h15);
        @(posedge clk); #1;
        chk("q_b2", 32'(sc_data), 32'hF0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ascii_ready), 1);
        chk("mid_rst_valid", 32'(sc_valid), 0);
        chk("mid_rst_data", 32'(sc_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_unmapped", 32'(unmapped), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", 32'(sc_valid), 0);
            chk("post_rst_ready", 32'(ascii_ready), 1);
        end
        send_check(7'h0A, 3, 48'h5AF05A000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
